counter_cell_scheduler: RTL

Priority scheduler for the AGC counter-cell increments. It latches plus/minus increment request pulses from peripherals (PIPAs, CDUs, timers) per counter cell. When the CPU offers a counter slot, it issues exactly one increment: a cell address on CAD plus a PINC or MINC command. It sits between the peripheral-interface logic and the `agc` sequence generator, and replaces hand-driven CAD1–CAD6/PINC/MINC stimulus in simulation.

---
 rtl/counter_cell_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/counter_cell_scheduler.sv
// Counter-cell increment scheduler: latches signed increment requests per cell and
// grants one increment (CAD + PINC/MINC) per CPU counter slot, lowest index first.
module counter_cell_scheduler #(
    parameter int NCELL = 16,
    parameter int TMO   = 64
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic [NCELL-1:0] PLSREQ,
    input  logic [NCELL-1:0] MNSREQ,
    input  logic             SLOT,
    input  logic             INKL,
    input  logic             INCDONE,
    output logic [5:0]       CAD,
    output logic             PINC,
    output logic             MINC,
    output logic             CNTBSY,
    output logic             PENDANY,
    output logic [7:0]       LOSTCT,
    output logic             CNTTMO
);

    localparam int TW = $clog2(TMO);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [NCELL-1:0] pend, pend_nxt;
    logic [NCELL-1:0] sign, sign_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [5:0]       cad_nxt;
    logic             pinc_nxt, minc_nxt, tmo_nxt;
    logic [7:0]       lost_nxt;

    logic             win_found, win_sign;
    logic [5:0]       win_idx;
    logic [NCELL-1:0] win_mask;
    logic [7:0]       lost_inc;
    logic [8:0]       lost_sum;
    logic             pend_eff;

    assign CNTBSY  = (state == BUSY);
    assign PENDANY = |pend;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cad_nxt   = CAD;
        pinc_nxt  = PINC;
        minc_nxt  = MINC;
        timer_nxt = timer;
        tmo_nxt   = CNTTMO;
        pend_nxt  = pend;
        sign_nxt  = sign;
        lost_inc  = 8'd0;
        win_found = 1'b0;
        win_sign  = 1'b0;
        win_idx   = 6'd0;
        win_mask  = '0;
        pend_eff  = 1'b0;

        // Lowest-index pending cell wins the slot.
        for (int i = 0; i < NCELL; i++) begin
            if (pend[i] && !win_found) begin
                win_found   = 1'b1;
                win_idx     = 6'(i);
                win_sign    = sign[i];
                win_mask[i] = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (SLOT && !INKL && win_found) begin
                    state_nxt = BUSY;
                    cad_nxt   = win_idx;
                    pinc_nxt  = win_sign;
                    minc_nxt  = !win_sign;
                    timer_nxt = '0;
                end else begin
                    win_mask = '0;
                end
            end
            BUSY: begin
                win_mask = '0;
                if (INCDONE || timer == TW'(TMO - 1)) begin
                    state_nxt = IDLE;
                    cad_nxt   = 6'd0;
                    pinc_nxt  = 1'b0;
                    minc_nxt  = 1'b0;
                    if (!INCDONE) begin
                        tmo_nxt  = 1'b1;
                        lost_inc = 8'd1;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A cell granted on this edge sees its request as arriving with PEND=0.
        for (int i = 0; i < NCELL; i++) begin
            pend_eff    = pend[i] & ~win_mask[i];
            pend_nxt[i] = pend_eff;
            if (PLSREQ[i] ^ MNSREQ[i]) begin
                if (!pend_eff) begin
                    pend_nxt[i] = 1'b1;
                    sign_nxt[i] = PLSREQ[i];
                end else if (sign[i] != PLSREQ[i]) begin
                    pend_nxt[i] = 1'b0;
                end else begin
                    lost_inc = lost_inc + 8'd1;
                end
            end
        end

        lost_sum = {1'b0, LOSTCT} + {1'b0, lost_inc};
        lost_nxt = (lost_sum > 9'd255) ? 8'hFF : lost_sum[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state  <= IDLE;
            pend   <= '0;
            sign   <= '0;
            timer  <= '0;
            CAD    <= 6'd0;
            PINC   <= 1'b0;
            MINC   <= 1'b0;
            LOSTCT <= 8'd0;
            CNTTMO <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            sign   <= sign_nxt;
            timer  <= timer_nxt;
            CAD    <= cad_nxt;
            PINC   <= pinc_nxt;
            MINC   <= minc_nxt;
            LOSTCT <= lost_nxt;
            CNTTMO <= tmo_nxt;
        end
    end

endmodule
